// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: shared state encoding and flow-control byte values for UART TX.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int DEFAULT_DATA_W = 8;

  localparam logic [7:0] XON  = 8'h11;
  localparam logic [7:0] XOFF = 8'h13;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter: combinational round-robin pick of the first request at or
// after the pointer, scanning upward with wrap. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o,
  output logic                       any_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = IDX_W'((int'(ptr_i) + off) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        idx_o         = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler: round-robin sharing of one UART TX core with CTS and
// XON/XOFF gating. Optional macro UART_TX_PKT_LOCK_EN keeps a requester
// granted until its req_last byte finishes. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DEFAULT_DATA_W,
  parameter int ACK_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_last,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        tx_start,
  output logic [DATA_W-1:0]           tx_data,
  input  logic                        tx_busy,
  input  logic                        cts,
  input  logic                        xoff_pulse,
  input  logic                        xon_pulse,
  output logic                        paused,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        timeout_err,
  output logic [CNT_W-1:0]            bytes_sent
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

  tx_state_e          state_q;
  logic [NUM_REQ-1:0] req_ready_q;
  logic               tx_start_q;
  logic [DATA_W-1:0]  tx_data_q;
  logic               paused_q;
  logic [IDX_W-1:0]   grant_id_q;
  logic               timeout_err_q;
  logic [CNT_W-1:0]   bytes_sent_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [TMO_W-1:0]   tmo_cnt_q;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               eligible;
  logic [DATA_W-1:0]  sel_data;
  logic [IDX_W-1:0]   ptr_inc;
  logic [IDX_W-1:0]   ptr_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i   (arb_req),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  assign eligible = arb_any && cts && !paused_q;
  assign ptr_inc  = (grant_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_id_q + IDX_W'(1);

`ifdef UART_TX_PKT_LOCK_EN
  logic lock_q;

  // While locked the pointer stays parked on the owner, so masking by the
  // pointer restricts arbitration to that single requester.
  assign arb_req = lock_q ? (req_valid & (NUM_REQ'(1) << ptr_q)) : req_valid;
  assign ptr_d   = lock_q ? grant_id_q : ptr_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q <= 1'b0;
    end else if (state_q == ST_IDLE && eligible) begin
      lock_q <= !req_last[arb_idx];
    end
  end
`else
  logic unused_req_last;

  assign unused_req_last = ^req_last;
  assign arb_req         = req_valid;
  assign ptr_d           = ptr_inc;
`endif

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) sel_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      paused_q      <= 1'b0;
      grant_id_q    <= '0;
      timeout_err_q <= 1'b0;
      bytes_sent_q  <= '0;
      ptr_q         <= '0;
      tmo_cnt_q     <= '0;
    end else begin
      req_ready_q   <= '0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;

      // XOFF takes precedence when both pulses coincide.
      if (xoff_pulse) begin
        paused_q <= 1'b1;
      end else if (xon_pulse) begin
        paused_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (eligible) begin
            tx_data_q   <= sel_data;
            grant_id_q  <= arb_idx;
            req_ready_q <= arb_grant;
            state_q     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          tx_start_q <= 1'b1;
          tmo_cnt_q  <= '0;
          state_q    <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (tx_busy) begin
            state_q <= ST_WAIT_DONE;
          end else if (tmo_cnt_q == TMO_W'(ACK_TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            ptr_q         <= ptr_d;
            state_q       <= ST_IDLE;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            bytes_sent_q <= bytes_sent_q + CNT_W'(1);
            ptr_q        <= ptr_d;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign paused      = paused_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;
  assign bytes_sent  = bytes_sent_q;

endmodule : uart_tx_scheduler

`default_nettype wire

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler: scoreboard bench with requester queues and a UART
// core model that stays busy for a fixed number of cycles. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx_scheduler;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 8;
  localparam int ACK_TIMEOUT = 16;
  localparam int CNT_W       = 16;
  localparam int BUSY_CYC    = 10;

  logic                      clk = 1'b0;
  logic                      reset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_start;
  logic [DATA_W-1:0]         tx_data;
  logic                      tx_busy;
  logic                      cts;
  logic                      xoff_pulse;
  logic                      xon_pulse;
  logic                      paused;
  logic [1:0]                grant_id;
  logic                      timeout_err;
  logic [CNT_W-1:0]          bytes_sent;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [8:0] rq [NUM_REQ][$];
  logic [9:0] exp_q [$];
  logic [9:0] exp_e;
  logic [8:0] popped;
  int         rise_cyc [NUM_REQ];
  int         n_start = 0;
  int         last_start_cyc = 0;
  logic [7:0] launched = '0;
  int         busy_cnt = 0;
  logic       core_en = 1'b1;

  uart_tx_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .DATA_W      (DATA_W),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .cts         (cts),
    .xoff_pulse  (xoff_pulse),
    .xon_pulse   (xon_pulse),
    .paused      (paused),
    .grant_id    (grant_id),
    .timeout_err (timeout_err),
    .bytes_sent  (bytes_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // UART core model: busy starts the cycle after tx_start and lasts BUSY_CYC cycles.
  assign tx_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (reset) busy_cnt <= 0;
    else if (tx_start && core_en) busy_cnt <= BUSY_CYC;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  // Requesters: present queue head, retire it on the req_ready pulse.
  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] && req_valid[i] && rq[i].size() > 0) popped = rq[i].pop_front();
      if (rq[i].size() > 0) begin
        if (!req_valid[i]) rise_cyc[i] = cyc;
        req_valid[i]            = 1'b1;
        req_data[i*DATA_W +: DATA_W] = rq[i][0][7:0];
        req_last[i]             = rq[i][0][8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
  end

  // Scoreboard: each launch must match the next expected {grant_id, byte}.
  always @(negedge clk) begin
    if (!reset) begin
      if (tx_start) begin
        n_start++;
        last_start_cyc = cyc;
        launched = tx_data;
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL launch_unexpected: got id %0d data %h, want no launch", grant_id, tx_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({grant_id, tx_data} !== exp_e)
            $display("FAIL launch_order: got id %0d data %h, want id %0d data %h",
                     grant_id, tx_data, exp_e[9:8], exp_e[7:0]);
          else n_pass++;
        end
      end else if (tx_busy) begin
        n_checks++;
        if (tx_data !== launched)
          $display("FAIL tx_data_stable: got %h, want %h", tx_data, launched);
        else n_pass++;
      end
    end
  end

  task automatic push_byte(input int id, input logic last, input logic [7:0] d);
    rq[id].push_back({last, d});
  endtask

  task automatic push_exp(input int id, input logic [7:0] d);
    exp_q.push_back({2'(id), d});
  endtask

  task automatic wait_bytes(input int target, input int bound, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (bytes_sent == CNT_W'(target)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b0)    $display("FAIL reset_req_ready: got %b want 0", req_ready); else n_pass++;
    n_checks++; if (tx_start !== 1'b0)     $display("FAIL reset_tx_start: got %b want 0", tx_start); else n_pass++;
    n_checks++; if (tx_data !== 8'h00)     $display("FAIL reset_tx_data: got %h want 00", tx_data); else n_pass++;
    n_checks++; if (paused !== 1'b0)       $display("FAIL reset_paused: got %b want 0", paused); else n_pass++;
    n_checks++; if (grant_id !== 2'd0)     $display("FAIL reset_grant_id: got %0d want 0", grant_id); else n_pass++;
    n_checks++; if (timeout_err !== 1'b0)  $display("FAIL reset_timeout_err: got %b want 0", timeout_err); else n_pass++;
    n_checks++; if (bytes_sent !== 16'd0)  $display("FAIL reset_bytes_sent: got %0d want 0", bytes_sent); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_round_robin;
    bit ok;
    @(posedge clk); #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      push_byte(i, 1'b1, 8'hA0 + 8'(i));
      push_exp(i, 8'hA0 + 8'(i));
    end
    wait_bytes(4, 300, ok);
    n_checks++; if (bytes_sent !== 16'd4) $display("FAIL rr_bytes_sent: got %0d want 4", bytes_sent); else n_pass++;
  endtask

  task automatic test_latency;
    bit ok;
    bit seen;
    @(posedge clk); #1;
    push_byte(2, 1'b1, 8'h5C);
    push_exp(2, 8'h5C);
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++; if (!seen) $display("FAIL lat_ready_seen: got none want pulse"); else n_pass++;
    n_checks++; if (req_ready !== 4'b0100) $display("FAIL lat_ready_onehot: got %b want 0100", req_ready); else n_pass++;
    n_checks++; if (cyc !== rise_cyc[2] + 1) $display("FAIL lat_ready_cycle: got %0d want %0d", cyc, rise_cyc[2] + 1); else n_pass++;
    @(negedge clk);
    n_checks++; if (tx_start !== 1'b1) $display("FAIL lat_tx_start: got %b want 1", tx_start); else n_pass++;
    n_checks++; if (req_ready !== 4'b0) $display("FAIL lat_ready_single: got %b want 0000", req_ready); else n_pass++;
    n_checks++; if (tx_data !== 8'h5C) $display("FAIL lat_tx_data: got %h want 5c", tx_data); else n_pass++;
    n_checks++; if (grant_id !== 2'd2) $display("FAIL lat_grant_id: got %0d want 2", grant_id); else n_pass++;
    wait_bytes(5, 60, ok);
    n_checks++; if (!ok) $display("FAIL lat_done: got bytes_sent %0d want 5", bytes_sent); else n_pass++;
  endtask

  task automatic test_pause;
    bit ok;
    bit seen;
    int s;
    @(posedge clk); #1;
    push_byte(0, 1'b1, 8'hB0);
    push_byte(1, 1'b1, 8'hB1);
    push_exp(0, 8'hB0);
    push_exp(1, 8'hB1);
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (tx_busy) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++; if (!seen) $display("FAIL pause_busy_seen: got idle want busy"); else n_pass++;
    @(posedge clk); #1; xoff_pulse = 1'b1;
    @(posedge clk); #1; xoff_pulse = 1'b0;
    wait_bytes(6, 40, ok);
    n_checks++; if (!ok) $display("FAIL pause_inflight_done: got bytes_sent %0d want 6", bytes_sent); else n_pass++;
    s = n_start;
    repeat (40) @(negedge clk);
    n_checks++; if (n_start !== s) $display("FAIL pause_blocks: got %0d launches want 0", n_start - s); else n_pass++;
    n_checks++; if (paused !== 1'b1) $display("FAIL pause_flag: got %b want 1", paused); else n_pass++;
    @(posedge clk); #1; xon_pulse = 1'b1;
    @(posedge clk); #1; xon_pulse = 1'b0;
    wait_bytes(7, 60, ok);
    n_checks++; if (!ok) $display("FAIL xon_resume: got bytes_sent %0d want 7", bytes_sent); else n_pass++;
    n_checks++; if (grant_id !== 2'd1) $display("FAIL xon_grant_id: got %0d want 1", grant_id); else n_pass++;
    @(posedge clk); #1; xoff_pulse = 1'b1; xon_pulse = 1'b1;
    @(posedge clk); #1; xoff_pulse = 1'b0; xon_pulse = 1'b0;
    @(negedge clk);
    n_checks++; if (paused !== 1'b1) $display("FAIL xoff_wins: got %b want 1", paused); else n_pass++;
    @(posedge clk); #1; xon_pulse = 1'b1;
    @(posedge clk); #1; xon_pulse = 1'b0;
    @(negedge clk);
    n_checks++; if (paused !== 1'b0) $display("FAIL xon_clears: got %b want 0", paused); else n_pass++;
  endtask

  task automatic test_cts;
    bit ok;
    bit seen;
    @(posedge clk); #1;
    cts = 1'b0;
    push_byte(3, 1'b1, 8'hC3);
    push_exp(3, 8'hC3);
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (req_ready != 0) seen = 1'b1;
    end
    n_checks++; if (seen) $display("FAIL cts_blocks: got req_ready pulse want none"); else n_pass++;
    @(posedge clk); #1;
    cts = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (req_ready !== 4'b1000) $display("FAIL cts_release: got %b want 1000", req_ready); else n_pass++;
    wait_bytes(8, 60, ok);
    n_checks++; if (!ok) $display("FAIL cts_done: got bytes_sent %0d want 8", bytes_sent); else n_pass++;
  endtask

  task automatic test_timeout;
    bit ok;
    bit seen;
    int s;
    int st;
    @(posedge clk); #1;
    core_en = 1'b0;
    s = n_start;
    push_byte(0, 1'b1, 8'hD0);
    push_byte(1, 1'b1, 8'hD1);
    push_exp(0, 8'hD0);
    push_exp(1, 8'hD1);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (n_start != s) break;
    end
    st = last_start_cyc;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (timeout_err) begin
        seen = 1'b1;
        break;
      end
    end
    core_en = 1'b1;
    n_checks++; if (!seen) $display("FAIL tmo_seen: got no pulse want pulse"); else n_pass++;
    n_checks++; if (cyc !== st + ACK_TIMEOUT) $display("FAIL tmo_cycle: got %0d want %0d", cyc, st + ACK_TIMEOUT); else n_pass++;
    n_checks++; if (bytes_sent !== 16'd8) $display("FAIL tmo_bytes_sent: got %0d want 8", bytes_sent); else n_pass++;
    @(negedge clk);
    n_checks++; if (timeout_err !== 1'b0) $display("FAIL tmo_pulse_width: got %b want 0", timeout_err); else n_pass++;
    wait_bytes(9, 60, ok);
    n_checks++; if (!ok) $display("FAIL tmo_next_done: got bytes_sent %0d want 9", bytes_sent); else n_pass++;
    n_checks++; if (grant_id !== 2'd1) $display("FAIL tmo_next_id: got %0d want 1", grant_id); else n_pass++;
  endtask

  task automatic test_pkt_order;
    bit ok;
    @(posedge clk); #1;
    push_byte(0, 1'b0, 8'hE0);
    push_byte(0, 1'b0, 8'hE1);
    push_byte(0, 1'b1, 8'hE2);
    push_byte(1, 1'b1, 8'hF0);
`ifdef UART_TX_PKT_LOCK_EN
    push_exp(0, 8'hE0);
    push_exp(0, 8'hE1);
    push_exp(0, 8'hE2);
    push_exp(1, 8'hF0);
`else
    push_exp(0, 8'hE0);
    push_exp(1, 8'hF0);
    push_exp(0, 8'hE1);
    push_exp(0, 8'hE2);
`endif
    wait_bytes(13, 300, ok);
    n_checks++; if (!ok) $display("FAIL pkt_done: got bytes_sent %0d want 13", bytes_sent); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b1;
    req_valid  = '0;
    req_data   = '0;
    req_last   = '0;
    cts        = 1'b1;
    xoff_pulse = 1'b0;
    xon_pulse  = 1'b0;

    test_reset();
    test_round_robin();
    test_latency();
    test_pause();
    test_cts();
    test_timeout();
    test_pkt_order();

    repeat (5) @(negedge clk);
    n_checks++; if (exp_q.size() != 0) $display("FAIL scoreboard_drained: got %0d left want 0", exp_q.size()); else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_tx_scheduler

`default_nettype wire

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares one UART transmitter core among NUM_REQ byte requesters using round-robin arbitration. Sequences the core through a start/busy handshake and holds off new bytes while CTS is low or an XOFF pause is active. Sits between the protocol-level byte sources and the UART transmitter; the receiver's XON/XOFF detector drives its pause inputs.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width
ACK_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before aborting
CNT_W, 16, width of the sent-byte counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NUM_REQ  per-requester byte valid; held until matching req_ready pulse
req_data  in  NUM_REQ*DATA_W  packed bytes; requester i uses bits [i*DATA_W +: DATA_W]
req_last  in  NUM_REQ  last byte of packet (used only with the optional feature)
req_ready  out  NUM_REQ  one-cycle acknowledge pulse; one-hot or zero
tx_start  out  1  one-cycle launch pulse to the UART core
tx_data  out  DATA_W  byte to the UART core; stable from tx_start until tx_busy falls
tx_busy  in  1  UART core busy
cts  in  1  clear to send, active-high
xoff_pulse  in  1  received XOFF (0x13), one-cycle
xon_pulse  in  1  received XON (0x11), one-cycle
paused  out  1  XOFF pause active
grant_id  out  $clog2(NUM_REQ)  requester currently or last served
timeout_err  out  1  one-cycle pulse on ACK_TIMEOUT abort
bytes_sent  out  CNT_W  count of completed bytes; wraps to 0

Behaviour:
- Reset: FSM=IDLE, req_ready=0, tx_start=0, tx_data=0, paused=0, grant_id=0, timeout_err=0, bytes_sent=0, RR pointer=0 (requester 0 has highest priority first).
- Reset mid-byte: abandons the byte and issues no req_ready again. The UART core is not notified.
- FSM states: IDLE, LAUNCH, WAIT_ACK, WAIT_DONE.
- IDLE: a byte is eligible when |req_valid && cts && !paused.
  - Winner = first set req_valid at or after the RR pointer, scanning upward with wrap.
  - On an eligible edge: latch req_data[winner] into tx_data; grant_id<=winner; req_ready[winner]<=1 for exactly one cycle; go to LAUNCH.
- LAUNCH: tx_start=1 for one cycle; go to WAIT_ACK. Latency is req_valid sampled at edge N, req_ready high in cycle N+1, tx_start high in cycle N+2.
- WAIT_ACK:
  - tx_busy=1: go to WAIT_DONE.
  - Otherwise, after ACK_TIMEOUT cycles: timeout_err pulse, bytes_sent unchanged, RR pointer advances, go to IDLE.
- WAIT_DONE: on tx_busy=0, bytes_sent+1 (mod 2^CNT_W), RR pointer<=winner+1 (mod NUM_REQ), go to IDLE. The next grant can occur on the following edge.
- Pause register:
  - xoff_pulse sets paused; xon_pulse clears it.
  - If both are high in the same cycle, XOFF wins.
  - paused and a low cts block only new grants; the byte already in flight completes.
- cts is sampled only in IDLE; deassertion in later states has no effect.
- A requester dropping req_valid before its req_ready is a protocol violation; the scheduler is not required to detect it.
- tx_data holds its last value in IDLE.

Optional Feature:
UART_TX_PKT_LOCK_EN
- Defined: after a grant whose req_last=0, the RR pointer is frozen on that requester. In IDLE only that requester is eligible until a byte with req_last=1 completes or times out. cts and paused still gate each byte.
- Undefined: arbitration is per byte and req_last is ignored (port kept, unused).

Decomposition:
- Shared package uart_pkg: FSM state enum, XON=8'h11, XOFF=8'h13 constants, default DATA_W.
- Sub-module rr_arbiter (NUM_REQ param; inputs req vector and pointer; outputs one-hot grant, index and any). It is purely combinational; the pointer register stays in the scheduler.

Test Plan:
- Reset, then req_valid=4'b1111 with bytes A0..A3 and the core model busy for 10 cycles each -> tx_data order A0,A1,A2,A3 and bytes_sent=4.
- Requester 2 only, valid at edge N -> req_ready[2] in cycle N+1, tx_start in N+2, tx_data=req_data[2], grant_id=2.
- xoff_pulse during WAIT_DONE with requesters 0,1 pending -> current byte completes and no further tx_start. xon_pulse -> requester 1 served next. xoff and xon in the same cycle -> paused=1.
- cts=0 with valid pending -> no req_ready for 100 cycles. cts=1 -> grant on the next edge.
- Core never asserts tx_busy -> timeout_err pulse exactly ACK_TIMEOUT cycles after WAIT_ACK entry, bytes_sent unchanged, next requester served.
- With UART_TX_PKT_LOCK_EN: requester 0 sends 3 bytes, last on the 3rd, while requester 1 is pending -> all 3 of requester 0's bytes go first, then requester 1. Without the macro, the order interleaves 0,1,0,0.
